if_id_fetch_stage: RTL and testbench

//  Instruction-fetch stage plus IF/ID pipeline register of the 5-stage MIPS core.

---
 rtl/if_id_fetch_stage.sv | 152 +++++++++++++++
 tb/tb_if_id_fetch_stage.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/if_id_fetch_stage.sv
// Instruction-fetch stage and IF/ID pipeline register for the 5-stage MIPS core.
// Owns the PC and issues one instruction-memory read per RUN cycle. Latches the
// fetched instruction with its PC for ID. Each RUN cycle applies one action, in
// this priority order: redirect flush, load-use stall, memory-wait bubble, advance.
// Optional build macro: IF_ID_PERF_EN adds saturating stall/flush/bubble counters.
module if_id_fetch_stage #(
    parameter int unsigned           ADDR_W   = 32,
    parameter int unsigned           INST_W   = 32,
    parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              stall_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ready_i,
    input  logic [INST_W-1:0] imem_rdata_i,
    output logic              if_id_valid_o,
    output logic [INST_W-1:0] if_id_instr_o,
    output logic [ADDR_W-1:0] if_id_pc_o,
`ifdef IF_ID_PERF_EN
    output logic [31:0]       perf_stall_o,
    output logic [31:0]       perf_flush_o,
    output logic [31:0]       perf_bubble_o,
`endif
    output logic [ADDR_W-1:0] if_id_pc4_o
);

    typedef enum logic [0:0] {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Sequential PC increment; wraps modulo 2^ADDR_W by construction.
    function automatic logic [ADDR_W-1:0] pc_plus4(input logic [ADDR_W-1:0] pc);
        pc_plus4 = pc + ADDR_W'(4);
    endfunction

    state_t            state_r, state_s;
    logic [ADDR_W-1:0] pc_r, pc_s;
    logic              valid_r, valid_s;
    logic [INST_W-1:0] instr_r, instr_s;
    logic [ADDR_W-1:0] id_pc_r, id_pc_s;
    logic [ADDR_W-1:0] id_pc4_r, id_pc4_s;
    logic              take_flush_s, take_stall_s, take_bubble_s;

    // Next-state and IF/ID update, resolving the per-cycle action priority.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        valid_s       = valid_r;
        instr_s       = instr_r;
        id_pc_s       = id_pc_r;
        id_pc4_s      = id_pc4_r;
        take_flush_s  = 1'b0;
        take_stall_s  = 1'b0;
        take_bubble_s = 1'b0;
        case (state_r)
            ST_BOOT: begin
                // Redirects are ignored here; fetch starts at RESET_PC.
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (redirect_i) begin
                    take_flush_s = 1'b1;
                    pc_s         = {redirect_pc_i[ADDR_W-1:2], 2'b00};
                    valid_s      = 1'b0;
                    instr_s      = {INST_W{1'b0}};
                    id_pc_s      = {ADDR_W{1'b0}};
                    id_pc4_s     = {ADDR_W{1'b0}};
                end else if (stall_i) begin
                    // Hold everything; any returned data is dropped and re-fetched.
                    take_stall_s = 1'b1;
                end else if (!imem_ready_i) begin
                    take_bubble_s = 1'b1;
                    valid_s       = 1'b0;
                    instr_s       = {INST_W{1'b0}};
                    id_pc_s       = {ADDR_W{1'b0}};
                    id_pc4_s      = {ADDR_W{1'b0}};
                end else begin
                    valid_s  = 1'b1;
                    instr_s  = imem_rdata_i;
                    id_pc_s  = pc_r;
                    id_pc4_s = pc_plus4(pc_r);
                    pc_s     = pc_plus4(pc_r);
                end
            end
            default: begin
                state_s = ST_BOOT;
            end
        endcase
    end

    // FSM, PC and IF/ID pipeline registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r  <= ST_BOOT;
            pc_r     <= RESET_PC;
            valid_r  <= 1'b0;
            instr_r  <= {INST_W{1'b0}};
            id_pc_r  <= {ADDR_W{1'b0}};
            id_pc4_r <= {ADDR_W{1'b0}};
        end else begin
            state_r  <= state_s;
            pc_r     <= pc_s;
            valid_r  <= valid_s;
            instr_r  <= instr_s;
            id_pc_r  <= id_pc_s;
            id_pc4_r <= id_pc4_s;
        end
    end

    assign imem_req_o    = (state_r == ST_RUN);
    assign imem_addr_o   = pc_r;
    assign if_id_valid_o = valid_r;
    assign if_id_instr_o = instr_r;
    assign if_id_pc_o    = id_pc_r;
    assign if_id_pc4_o   = id_pc4_r;

`ifdef IF_ID_PERF_EN
    // Saturating event counter increment.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        sat_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;
    endfunction

    logic [31:0] perf_stall_r, perf_flush_r, perf_bubble_r;

    // Performance counters for stall, flush and memory-wait bubble cycles.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            perf_stall_r  <= 32'd0;
            perf_flush_r  <= 32'd0;
            perf_bubble_r <= 32'd0;
        end else begin
            perf_stall_r  <= take_stall_s  ? sat_inc(perf_stall_r)  : perf_stall_r;
            perf_flush_r  <= take_flush_s  ? sat_inc(perf_flush_r)  : perf_flush_r;
            perf_bubble_r <= take_bubble_s ? sat_inc(perf_bubble_r) : perf_bubble_r;
        end
    end

    assign perf_stall_o  = perf_stall_r;
    assign perf_flush_o  = perf_flush_r;
    assign perf_bubble_o = perf_bubble_r;
`else
    // Event flags have no consumer when the counters are not built.
    logic unused_s;
    assign unused_s = take_flush_s ^ take_stall_s ^ take_bubble_s;
`endif

endmodule

// File: tb/tb_if_id_fetch_stage.sv
// Directed self-checking bench for if_id_fetch_stage (optionally with IF_ID_PERF_EN).
module tb_if_id_fetch_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ready_i;
    logic [31:0] imem_rdata_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_instr_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
`ifdef IF_ID_PERF_EN
    logic [31:0] perf_stall_o, perf_flush_o, perf_bubble_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    if_id_fetch_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .stall_i       (stall_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ready_i  (imem_ready_i),
        .imem_rdata_i  (imem_rdata_i),
        .if_id_valid_o (if_id_valid_o),
        .if_id_instr_o (if_id_instr_o),
        .if_id_pc_o    (if_id_pc_o),
`ifdef IF_ID_PERF_EN
        .perf_stall_o  (perf_stall_o),
        .perf_flush_o  (perf_flush_o),
        .perf_bubble_o (perf_bubble_o),
`endif
        .if_id_pc4_o   (if_id_pc4_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic v, input logic [31:0] ins,
                              input logic [31:0] pc, input logic [31:0] addr);
        check_eq({tag, "_valid"}, {31'd0, if_id_valid_o}, {31'd0, v});
        check_eq({tag, "_instr"}, if_id_instr_o, ins);
        check_eq({tag, "_pc"},    if_id_pc_o, pc);
        check_eq({tag, "_pc4"},   if_id_pc4_o, v ? pc + 32'd4 : 32'd0);
        check_eq({tag, "_addr"},  imem_addr_o, addr);
        check_eq({tag, "_req"},   {31'd0, imem_req_o}, 32'd1);
    endtask

    initial begin
        rst_i         = 1'b0;
        stall_i       = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'd0;
        imem_ready_i  = 1'b0;
        imem_rdata_i  = 32'd0;
        #12;
        // T1: reset state, then exactly one BOOT cycle without request
        check_eq("rst_req",   {31'd0, imem_req_o}, 32'd0);
        check_eq("rst_valid", {31'd0, if_id_valid_o}, 32'd0);
        check_eq("rst_addr",  imem_addr_o, 32'd0);
        check_eq("rst_instr", if_id_instr_o, 32'd0);
        rst_i = 1'b1;
        #1;
        check_eq("boot_req", {31'd0, imem_req_o}, 32'd0);
        tick();
        check_ifid("run0", 1'b0, 32'd0, 32'd0, 32'd0);

        // T2: streaming
        imem_ready_i = 1'b1;
        imem_rdata_i = 32'hA0; tick(); check_ifid("s0", 1'b1, 32'hA0, 32'h0, 32'h4);
        imem_rdata_i = 32'hA1; tick(); check_ifid("s1", 1'b1, 32'hA1, 32'h4, 32'h8);
        imem_rdata_i = 32'hA2; tick(); check_ifid("s2", 1'b1, 32'hA2, 32'h8, 32'hC);

        // T3: stall with ready=1, fetched data dropped
        stall_i = 1'b1; imem_rdata_i = 32'hDEAD;
        tick(); check_ifid("st0", 1'b1, 32'hA2, 32'h8, 32'hC);
        tick(); check_ifid("st1", 1'b1, 32'hA2, 32'h8, 32'hC);
        stall_i = 1'b0; imem_rdata_i = 32'hA3;
        tick(); check_ifid("st_rel", 1'b1, 32'hA3, 32'hC, 32'h10);

        // T4: redirect beats stall, target aligned down
        redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h103;
        tick(); check_ifid("flush", 1'b0, 32'd0, 32'd0, 32'h100);
        redirect_i = 1'b0; stall_i = 1'b0;

        // T5: memory wait bubbles
        imem_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); check_ifid("wait", 1'b0, 32'd0, 32'd0, 32'h100);
        end
`ifdef IF_ID_PERF_EN
        check_eq("perf_bubble", perf_bubble_o, 32'd3);
        check_eq("perf_stall",  perf_stall_o,  32'd2);
        check_eq("perf_flush",  perf_flush_o,  32'd1);
`endif
        imem_ready_i = 1'b1; imem_rdata_i = 32'hB0;
        tick(); check_ifid("resume", 1'b1, 32'hB0, 32'h100, 32'h104);

        // T6: wrap-around and asynchronous reset
        redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFE;
        tick(); check_ifid("to_top", 1'b0, 32'd0, 32'd0, 32'hFFFF_FFFC);
        redirect_i = 1'b0; imem_rdata_i = 32'hC0;
        tick(); check_ifid("wrap", 1'b1, 32'hC0, 32'hFFFF_FFFC, 32'h0);
        imem_rdata_i = 32'hC1;
        tick(); check_ifid("post_wrap", 1'b1, 32'hC1, 32'h0, 32'h4);
        #2;
        rst_i = 1'b0;
        #1;
        check_eq("arst_req",   {31'd0, imem_req_o}, 32'd0);
        check_eq("arst_valid", {31'd0, if_id_valid_o}, 32'd0);
        check_eq("arst_instr", if_id_instr_o, 32'd0);
        check_eq("arst_pc",    if_id_pc_o, 32'd0);
        check_eq("arst_pc4",   if_id_pc4_o, 32'd0);
        check_eq("arst_addr",  imem_addr_o, 32'd0);
`ifdef IF_ID_PERF_EN
        check_eq("arst_perf", perf_flush_o | perf_stall_o | perf_bubble_o, 32'd0);
`endif

        // Redirect during BOOT is ignored
        redirect_i = 1'b1; redirect_pc_i = 32'h200;
        @(negedge clk_i);
        rst_i = 1'b1;
        tick(); check_ifid("boot_redir", 1'b0, 32'd0, 32'd0, 32'd0);
        redirect_i = 1'b0; imem_rdata_i = 32'hD0;
        tick(); check_ifid("boot_run", 1'b1, 32'hD0, 32'h0, 32'h4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
